console_compositor: RTL and testbench
=====================================

Name: console_compositor

Overview:
- Parametrised console top-level controller. Composites pixel streams from N_GAMES game engines and one banner generator onto the VGA monitor.
- Owns the session state machine (idle/regen/run/pause/win/lose), rating, run timer and layout mode (split-screen or solo-focus).
- Sits between the per-game engine/graphics instances and the monitor/quad display. It replaces fixed two-game muxing with N-tile layout and frame-synchronous mode switching.

Parameters:
- N_GAMES, 2, number of game channels (1..8).
- SCREEN_WIDTH, 800, visible pixels per line.
- SCREEN_HEIGHT, 600, visible lines.
- RATING_WIDTH, 8, rating counter width.
- TIMER_WIDTH, 16, run-timer width (frames).
- BORDER_W, 2, divider width in pixels (BORDER_EN only).
- BORDER_COLOR, 12'hFFF, divider RGB444 (BORDER_EN only).

Ports:
- clk  in  1  system clock
- arst_n  in  1  asynchronous active-low reset
- monitor_h_coord  in  11  pixel x
- monitor_v_coord  in  10  pixel y
- monitor_enable  in  1  display enable
- game_rgb  in  12*N_GAMES  per-game RGB444; game k at [12k+11:12k]
- game_win  in  N_GAMES  per-game win level
- game_lose  in  N_GAMES  per-game lose level
- game_ready  in  N_GAMES  per-game regen-done level
- banner_rgb  in  12  banner pixel
- button_start  in  1  synchronised level
- button_pause  in  1  synchronised level
- button_next  in  1  synchronised level
- tile_x  out  11  h_coord minus current tile start (combinational)
- game_pause  out  N_GAMES  per-game pause
- game_regen  out  N_GAMES  one-cycle regen pulse per game
- banner_num  out  2  0 idle, 1 paused, 2 win, 3 lose
- game_running  out  1  state==RUN
- rating  out  RATING_WIDTH  current rating
- monitor_r  out  4  red
- monitor_g  out  4  green
- monitor_b  out  4  blue
- quad_disp  out  32  {timer[15:0], 4'b0, solo, focus[2:0], rating[7:0]}

Behaviour:
- Reset (arst_n=0, asynchronous):
  - state=IDLE; mode=SPLIT; focus=0; pending mode cleared; rating=0; timer=0.
  - game_regen=0; game_pause=all 1s; banner_num=0; game_running=0.
  - monitor_r/g/b=0 from the first cycle of reset.
- Button edges: each button is rising-edge detected with one register; every button action occurs on the edge cycle only.
- Active set:
  - SPLIT: all games active.
  - SOLO: only game[focus] active.
  - game_pause[k] = ~(state==RUN && k active).
- FSM:
  - IDLE: start edge -> REGEN.
  - REGEN: on entry, game_regen[k]=1 for exactly one cycle for each active k; timer cleared. Advance to RUN when all active game_ready bits are 1, sampled no earlier than the cycle after the pulse.
  - RUN:
    - Any active lose -> LOSE; rating decrements, saturating at 0.
    - Otherwise any active win -> WIN; rating increments, saturating at 2^RATING_WIDTH-1.
    - Otherwise pause edge -> PAUSED.
    - Priority: lose > win > pause when they occur in the same cycle.
    - Win/lose from inactive games is ignored.
  - PAUSED: pause edge or start edge -> RUN.
  - WIN/LOSE: start edge -> REGEN.
  - banner_num encodes state: IDLE/REGEN=0, PAUSED=1, WIN=2, LOSE=3.
- Mode switch:
  - button_next edge is accepted only in IDLE or PAUSED; ignored elsewhere.
  - Sequence: SPLIT -> SOLO focus 0 -> SOLO focus 1 -> ... -> SOLO focus N_GAMES-1 -> SPLIT.
  - A new request is latched as pending and overwrites any prior pending request.
  - Pending mode is applied on the frame-start cycle, the first clk where h==0 && v==0, detected by edge of that condition.
  - Mode never changes mid-frame.
- Timer: increments once per frame-start while in RUN; saturates at all 1s; cleared on REGEN entry.
- Pixel path:
  - Output is registered: colour for coordinates sampled at cycle t appears at t+1.
  - monitor_enable=0 -> output 0.
  - state != RUN -> banner_rgb.
  - SPLIT: tile width TW = SCREEN_WIDTH/N_GAMES (integer). Tile index is found by comparator chain; h >= N_GAMES*TW maps to the last tile.
  - SOLO: game[focus] drives the full width and tile_x = h.
  - h >= SCREEN_WIDTH or v >= SCREEN_HEIGHT with enable=1 -> output 0.
- Reset mid-REGEN or mid-frame: all state returns to reset values immediately; no regen pulse is issued after reset release.

Optional Feature:
- Macro: CONSOLE_COMPOSITOR_BORDER_EN.
- Defined: in SPLIT mode during RUN, pixels with h in [k*TW - BORDER_W, k*TW) for k=1..N_GAMES-1 output BORDER_COLOR instead of game pixels.
- Undefined: no dividers; the BORDER_W and BORDER_COLOR parameters have no effect.

Test Plan:
- Reset, then start edge (N_GAMES=2), then hold game_ready=2'b11 -> game_regen=2'b11 for 1 cycle; RUN 1 cycle after ready; game_pause=2'b00; game_running=1.
- RUN, game_win=01 and game_lose=10 in the same cycle -> state LOSE, banner_num=3, rating stays 0 (saturated).
- Rating at 255 (RATING_WIDTH=8), game_win pulse -> WIN, rating stays 255; start edge -> REGEN, timer=0.
- PAUSED, three next edges (N=2) -> pending applies only at next h=0,v=0: after 1st edge SOLO focus 0, 2nd focus 1, 3rd SPLIT. Next edge in RUN is ignored.
- RUN SPLIT N=4, h=0, 199, 200, 799 -> colour of game 0, 0, 1, 3 one cycle later; tile_x=0, 199, 0, 199; monitor_enable=0 -> 0.
- CONSOLE_COMPOSITOR_BORDER_EN defined, N=2, BORDER_W=2, h=398, 399 -> 12'hFFF; h=400 -> game 1 pixel.

Source files
------------

// File: rtl/console_compositor.sv
// -----------------------------------------------------------------------------
// console_compositor
//
// Console top-level controller. Runs the session state machine
// (idle / regen / run / paused / win / lose), keeps the rating and the run
// timer, and owns the screen layout (split-screen across all games, or solo
// focus on one game). It composites the game pixel streams and the banner
// pixel onto the VGA monitor with one register stage.
//
// Optional feature:
//   CONSOLE_COMPOSITOR_BORDER_EN - when defined, draws BORDER_W-pixel dividers
//   in BORDER_COLOR just left of each tile boundary in split mode during RUN.
//   When undefined, BORDER_W and BORDER_COLOR have no effect.
//
// Ports:
//   clk, arst_n          clock, asynchronous active-low reset
//   monitor_h_coord/v    current pixel coordinates from the VGA timing block
//   monitor_enable       visible-area enable from the VGA timing block
//   game_rgb             RGB444 per game, game k at [12k+11:12k]
//   game_win/lose/ready  per-game status levels
//   banner_rgb           banner generator pixel
//   button_start/pause/next  synchronised button levels
//   tile_x               h coordinate relative to the current tile (comb)
//   game_pause           per-game pause (low only for active games in RUN)
//   game_regen           one-cycle regenerate pulse per active game
//   banner_num           0 idle/regen, 1 paused, 2 win, 3 lose
//   game_running         high while in RUN
//   rating               current rating
//   monitor_r/g/b        registered RGB444 monitor output
//   quad_disp            {timer[15:0], 4'b0, solo, focus[2:0], rating[7:0]}
// -----------------------------------------------------------------------------
module console_compositor #(
  parameter int          N_GAMES       = 2,
  parameter int          SCREEN_WIDTH  = 800,
  parameter int          SCREEN_HEIGHT = 600,
  parameter int          RATING_WIDTH  = 8,
  parameter int          TIMER_WIDTH   = 16,
  parameter int          BORDER_W      = 2,
  parameter logic [11:0] BORDER_COLOR  = 12'hFFF
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [10:0]             monitor_h_coord,
  input  logic [9:0]              monitor_v_coord,
  input  logic                    monitor_enable,
  input  logic [12*N_GAMES-1:0]   game_rgb,
  input  logic [N_GAMES-1:0]      game_win,
  input  logic [N_GAMES-1:0]      game_lose,
  input  logic [N_GAMES-1:0]      game_ready,
  input  logic [11:0]             banner_rgb,
  input  logic                    button_start,
  input  logic                    button_pause,
  input  logic                    button_next,
  output logic [10:0]             tile_x,
  output logic [N_GAMES-1:0]      game_pause,
  output logic [N_GAMES-1:0]      game_regen,
  output logic [1:0]              banner_num,
  output logic                    game_running,
  output logic [RATING_WIDTH-1:0] rating,
  output logic [3:0]              monitor_r,
  output logic [3:0]              monitor_g,
  output logic [3:0]              monitor_b,
  output logic [31:0]             quad_disp
);

  localparam int TW = SCREEN_WIDTH / N_GAMES;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REGEN  = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_PAUSED = 3'd3;
  localparam logic [2:0] ST_WIN    = 3'd4;
  localparam logic [2:0] ST_LOSE   = 3'd5;

  logic [2:0]             state;
  logic                   regen_wait;
  logic [TIMER_WIDTH-1:0] timer;

  logic       start_q, pause_q, next_q;
  logic       start_edge, pause_edge, next_edge;
  logic       fs_cond, fs_q, frame_start;

  logic       solo;
  logic [2:0] focus;
  logic       pend_valid;
  logic       pend_solo;
  logic [2:0] pend_focus;
  logic       next_solo;
  logic [2:0] next_focus;

  logic [N_GAMES-1:0] active;
  logic               all_ready, win_any, lose_any, enter_regen;

  logic [2:0]  tile_idx;
  logic [10:0] tile_start;
  logic [2:0]  sel_idx;
  logic [11:0] game_pix;
  logic        in_border;
  logic [11:0] pix_nx, pix_q;

  // Button and frame-start edge detection: one history register each, so
  // every action fires only on the cycle the level first goes high.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      start_q <= 1'b0;
      pause_q <= 1'b0;
      next_q  <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      start_q <= button_start;
      pause_q <= button_pause;
      next_q  <= button_next;
      fs_q    <= fs_cond;
    end
  end

  assign start_edge  = button_start & ~start_q;
  assign pause_edge  = button_pause & ~pause_q;
  assign next_edge   = button_next  & ~next_q;
  assign fs_cond     = (monitor_h_coord == 11'd0) && (monitor_v_coord == 10'd0);
  assign frame_start = fs_cond & ~fs_q;

  // Active-game mask: every game in split mode, only the focused one in solo.
  always_comb begin
    active = '0;
    for (int k = 0; k < N_GAMES; k++) begin
      active[k] = !solo || (focus == 3'(k));
    end
  end

  // Inactive games never hold up regen and never end a run.
  assign all_ready = &(game_ready | ~active);
  assign win_any   = |(game_win  & active);
  assign lose_any  = |(game_lose & active);

  assign enter_regen = start_edge &&
                       ((state == ST_IDLE) || (state == ST_WIN) || (state == ST_LOSE));

  // Session state machine with rating and run timer. On regen entry the pulse
  // is issued for one cycle and ready is only looked at from the following
  // cycle, so a game still showing ready from the previous round cannot
  // short-circuit its own regeneration.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= ST_IDLE;
      regen_wait <= 1'b0;
      game_regen <= '0;
      timer      <= '0;
      rating     <= '0;
    end else begin
      game_regen <= '0;
      if (enter_regen) begin
        state      <= ST_REGEN;
        game_regen <= active;
        regen_wait <= 1'b1;
        timer      <= '0;
      end else begin
        case (state)
          ST_REGEN: begin
            if (regen_wait) begin
              regen_wait <= 1'b0;
            end else if (all_ready) begin
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (lose_any) begin
              state <= ST_LOSE;
              if (rating != '0) rating <= rating - 1'b1;
            end else if (win_any) begin
              state <= ST_WIN;
              if (rating != '1) rating <= rating + 1'b1;
            end else if (pause_edge) begin
              state <= ST_PAUSED;
            end
            if (frame_start && (timer != '1)) begin
              timer <= timer + 1'b1;
            end
          end
          ST_PAUSED: begin
            if (pause_edge || start_edge) state <= ST_RUN;
          end
          ST_IDLE, ST_WIN, ST_LOSE: begin
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Next layout in the cycle SPLIT -> SOLO 0 -> ... -> SOLO N-1 -> SPLIT.
  // Requests chain off a still-pending request, so several presses inside
  // one frame step several positions; the newest target replaces the old.
  always_comb begin
    logic       base_solo;
    logic [2:0] base_focus;
    base_solo  = pend_valid ? pend_solo  : solo;
    base_focus = pend_valid ? pend_focus : focus;
    next_solo  = 1'b1;
    next_focus = 3'd0;
    if (!base_solo) begin
      next_solo  = 1'b1;
      next_focus = 3'd0;
    end else if (base_focus == 3'(N_GAMES - 1)) begin
      next_solo  = 1'b0;
      next_focus = 3'd0;
    end else begin
      next_solo  = 1'b1;
      next_focus = base_focus + 3'd1;
    end
  end

  // Layout register: requests are accepted only in IDLE or PAUSED and the
  // layout itself only changes on a frame start, so a frame is never torn.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      solo       <= 1'b0;
      focus      <= 3'd0;
      pend_valid <= 1'b0;
      pend_solo  <= 1'b0;
      pend_focus <= 3'd0;
    end else begin
      if (frame_start && pend_valid) begin
        solo       <= pend_solo;
        focus      <= pend_focus;
        pend_valid <= 1'b0;
      end
      if (next_edge && ((state == ST_IDLE) || (state == ST_PAUSED))) begin
        pend_valid <= 1'b1;
        pend_solo  <= next_solo;
        pend_focus <= next_focus;
      end
    end
  end

  // Tile lookup by comparator chain; anything past N_GAMES*TW stays in the
  // last tile because no later comparator can claim it.
  always_comb begin
    tile_idx   = 3'd0;
    tile_start = 11'd0;
    for (int k = 1; k < N_GAMES; k++) begin
      if (monitor_h_coord >= 11'(k * TW)) begin
        tile_idx   = 3'(k);
        tile_start = 11'(k * TW);
      end
    end
  end

  assign tile_x  = solo ? monitor_h_coord : (monitor_h_coord - tile_start);
  assign sel_idx = solo ? focus : tile_idx;

  always_comb begin
    game_pix = 12'h000;
    for (int k = 0; k < N_GAMES; k++) begin
      if (sel_idx == 3'(k)) game_pix = game_rgb[k*12 +: 12];
    end
  end

`ifdef CONSOLE_COMPOSITOR_BORDER_EN
  // Divider band sits just left of each internal tile boundary.
  always_comb begin
    in_border = 1'b0;
    if (!solo) begin
      for (int k = 1; k < N_GAMES; k++) begin
        if ((k * TW >= BORDER_W) &&
            (monitor_h_coord >= 11'(k * TW - BORDER_W)) &&
            (monitor_h_coord <  11'(k * TW))) begin
          in_border = 1'b1;
        end
      end
    end
  end
`else
  assign in_border = 1'b0;
  logic unused_border_cfg;
  assign unused_border_cfg = ^{BORDER_COLOR, 32'(BORDER_W)};
`endif

  // Pixel source selection: blanking and off-screen coordinates are black,
  // any non-RUN state shows the banner, RUN shows the game layout.
  always_comb begin
    pix_nx = 12'h000;
    if (!monitor_enable) begin
      pix_nx = 12'h000;
    end else if ((monitor_h_coord >= 11'(SCREEN_WIDTH)) ||
                 (monitor_v_coord >= 10'(SCREEN_HEIGHT))) begin
      pix_nx = 12'h000;
    end else if (state != ST_RUN) begin
      pix_nx = banner_rgb;
    end else if (in_border) begin
`ifdef CONSOLE_COMPOSITOR_BORDER_EN
      pix_nx = BORDER_COLOR;
`else
      pix_nx = game_pix;
`endif
    end else begin
      pix_nx = game_pix;
    end
  end

  // One-cycle registered monitor output; black while in reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pix_q <= 12'h000;
    end else begin
      pix_q <= pix_nx;
    end
  end

  assign monitor_r = pix_q[11:8];
  assign monitor_g = pix_q[7:4];
  assign monitor_b = pix_q[3:0];

  assign game_running = (state == ST_RUN);
  assign game_pause   = ~(active & {N_GAMES{state == ST_RUN}});

  always_comb begin
    case (state)
      ST_PAUSED: banner_num = 2'd1;
      ST_WIN:    banner_num = 2'd2;
      ST_LOSE:   banner_num = 2'd3;
      default:   banner_num = 2'd0;
    endcase
  end

  assign quad_disp = {16'(timer), 4'b0000, solo, focus, 8'(rating)};

endmodule

// File: tb/tb_console_compositor.sv
// -----------------------------------------------------------------------------
// tb_console_compositor
//
// Self-checking bench. dut2 (two games) exercises the session FSM, rating
// saturation, timer, layout switching, solo mode, dividers and reset. dut4
// (four games) is driven through a table of split-screen pixel vectors.
// -----------------------------------------------------------------------------
module tb_console_compositor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst_n;

  // two-game instance
  logic [10:0] h2;
  logic [9:0]  v2;
  logic        en2;
  logic [23:0] rgb_in2;
  logic [1:0]  win2, lose2, ready2;
  logic [11:0] banner_in2;
  logic        start2, pause2, next2;
  logic [10:0] tile_x2;
  logic [1:0]  gpause2, regen2, banner2;
  logic        running2;
  logic [7:0]  rating2;
  logic [3:0]  r2, g2, b2;
  logic [31:0] quad2;
  logic [11:0] rgb2;

  // four-game instance
  logic [10:0] h4;
  logic [9:0]  v4;
  logic        en4;
  logic [47:0] rgb_in4;
  logic [3:0]  win4, lose4, ready4;
  logic [11:0] banner_in4;
  logic        start4, pause4, next4;
  logic [10:0] tile_x4;
  logic [3:0]  gpause4, regen4;
  logic [1:0]  banner4;
  logic        running4;
  logic [7:0]  rating4;
  logic [3:0]  r4, g4, b4;
  logic [31:0] quad4;
  logic [11:0] rgb4;

  assign rgb2 = {r2, g2, b2};
  assign rgb4 = {r4, g4, b4};

  console_compositor #(.N_GAMES(2)) dut2 (
    .clk(clk), .arst_n(arst_n),
    .monitor_h_coord(h2), .monitor_v_coord(v2), .monitor_enable(en2),
    .game_rgb(rgb_in2), .game_win(win2), .game_lose(lose2), .game_ready(ready2),
    .banner_rgb(banner_in2),
    .button_start(start2), .button_pause(pause2), .button_next(next2),
    .tile_x(tile_x2), .game_pause(gpause2), .game_regen(regen2),
    .banner_num(banner2), .game_running(running2), .rating(rating2),
    .monitor_r(r2), .monitor_g(g2), .monitor_b(b2), .quad_disp(quad2)
  );

  console_compositor #(.N_GAMES(4)) dut4 (
    .clk(clk), .arst_n(arst_n),
    .monitor_h_coord(h4), .monitor_v_coord(v4), .monitor_enable(en4),
    .game_rgb(rgb_in4), .game_win(win4), .game_lose(lose4), .game_ready(ready4),
    .banner_rgb(banner_in4),
    .button_start(start4), .button_pause(pause4), .button_next(next4),
    .tile_x(tile_x4), .game_pause(gpause4), .game_regen(regen4),
    .banner_num(banner4), .game_running(running4), .rating(rating4),
    .monitor_r(r4), .monitor_g(g4), .monitor_b(b4), .quad_disp(quad4)
  );

  localparam logic [11:0] G0_2 = 12'h123;
  localparam logic [11:0] G1_2 = 12'h456;
  localparam logic [11:0] BAN2 = 12'h789;

`ifdef CONSOLE_COMPOSITOR_BORDER_EN
  localparam logic [11:0] EXP398 = 12'hFFF;
  localparam logic [11:0] EXP399 = 12'hFFF;
  localparam logic [11:0] EXP199 = 12'hFFF;
`else
  localparam logic [11:0] EXP398 = G0_2;
  localparam logic [11:0] EXP399 = G0_2;
  localparam logic [11:0] EXP199 = 12'hA01;
`endif

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic        en;
    logic [11:0] exp_rgb;
    logic [10:0] exp_tx;
  } pix_vec_t;

  pix_vec_t vecs[8];

  int vec_count  = 0;
  int miscompares = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one table vector on dut4, check tile_x combinationally and the
  // registered colour one cycle later.
  task automatic applyStimulus(input pix_vec_t vec, input int idx);
    h4  = vec.h;
    v4  = vec.v;
    en4 = vec.en;
    #1;
    checkOutput($sformatf("vec%0d_tile_x", idx), 32'(tile_x4), 32'(vec.exp_tx));
    @(negedge clk);
    checkOutput($sformatf("vec%0d_rgb", idx), 32'(rgb4), 32'(vec.exp_rgb));
  endtask

  task automatic press2(input int which);
    if (which == 0) start2 = 1'b1;
    else if (which == 1) pause2 = 1'b1;
    else next2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    pause2 = 1'b0;
    next2  = 1'b0;
  endtask

  task automatic frameStart2();
    h2 = 11'd0;
    v2 = 10'd0;
    @(negedge clk);
    h2 = 11'd5;
    v2 = 10'd5;
    @(negedge clk);
  endtask

  task automatic waitRun2(input string name);
    for (int i = 0; i < 8 && !running2; i++) @(negedge clk);
    if (!running2) checkOutput(name, 32'(running2), 32'd1);
  endtask

  initial begin
    arst_n = 1'b0;
    h2 = 11'd5; v2 = 10'd5; en2 = 1'b1;
    rgb_in2 = {G1_2, G0_2}; banner_in2 = BAN2;
    win2 = '0; lose2 = '0; ready2 = '0;
    start2 = 1'b0; pause2 = 1'b0; next2 = 1'b0;
    h4 = 11'd5; v4 = 10'd5; en4 = 1'b1;
    rgb_in4 = {12'hD34, 12'hC23, 12'hB12, 12'hA01}; banner_in4 = 12'h5A5;
    win4 = '0; lose4 = '0; ready4 = 4'hF;
    start4 = 1'b0; pause4 = 1'b0; next4 = 1'b0;

    vecs[0] = '{11'd0,   10'd10,  1'b1, 12'hA01, 11'd0};
    vecs[1] = '{11'd199, 10'd10,  1'b1, EXP199,  11'd199};
    vecs[2] = '{11'd200, 10'd10,  1'b1, 12'hB12, 11'd0};
    vecs[3] = '{11'd799, 10'd10,  1'b1, 12'hD34, 11'd199};
    vecs[4] = '{11'd450, 10'd10,  1'b1, 12'hC23, 11'd50};
    vecs[5] = '{11'd850, 10'd10,  1'b1, 12'h000, 11'd250};
    vecs[6] = '{11'd10,  10'd650, 1'b1, 12'h000, 11'd10};
    vecs[7] = '{11'd10,  10'd10,  1'b0, 12'h000, 11'd10};

    // Reset values while reset is held
    @(negedge clk);
    checkOutput("rst_rgb", 32'(rgb2), 32'h0);
    checkOutput("rst_pause", 32'(gpause2), 32'h3);
    checkOutput("rst_banner", 32'(banner2), 32'h0);
    checkOutput("rst_running", 32'(running2), 32'h0);
    checkOutput("rst_regen", 32'(regen2), 32'h0);
    checkOutput("rst_quad", quad2, 32'h0);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_banner_pix", 32'(rgb2), 32'(BAN2));

    // Start: one-cycle regen pulse, RUN one cycle after ready
    press2(0);
    checkOutput("regen_pulse", 32'(regen2), 32'h3);
    checkOutput("regen_not_run", 32'(running2), 32'h0);
    @(negedge clk);
    checkOutput("regen_pulse_end", 32'(regen2), 32'h0);
    checkOutput("regen_wait_ready", 32'(running2), 32'h0);
    ready2 = 2'b11;
    @(negedge clk);
    checkOutput("run_entered", 32'(running2), 32'h1);
    checkOutput("run_pause", 32'(gpause2), 32'h0);

    // Timer counts frame starts in RUN; split pixel at h=5 is game 0
    repeat (3) frameStart2();
    checkOutput("timer_3", 32'(quad2[31:16]), 32'd3);
    checkOutput("split_pix_g0", 32'(rgb2), 32'(G0_2));

    // Lose beats win in the same cycle; rating saturates at 0
    win2 = 2'b01; lose2 = 2'b10;
    @(negedge clk);
    win2 = '0; lose2 = '0;
    checkOutput("lose_banner", 32'(banner2), 32'd3);
    checkOutput("lose_rating", 32'(rating2), 32'd0);
    checkOutput("lose_pause", 32'(gpause2), 32'h3);

    // Climb the rating to its ceiling
    for (int i = 0; i < 255; i++) begin
      press2(0);
      waitRun2("run_timeout");
      win2 = 2'b01;
      @(negedge clk);
      win2 = '0;
    end
    checkOutput("rating_255", 32'(rating2), 32'd255);
    checkOutput("win_banner", 32'(banner2), 32'd2);

    press2(0);
    waitRun2("run_timeout_sat");
    repeat (2) frameStart2();
    win2 = 2'b10;
    @(negedge clk);
    win2 = '0;
    checkOutput("rating_sat", 32'(rating2), 32'd255);
    checkOutput("win_timer", 32'(quad2[31:16]), 32'd2);
    checkOutput("quad_rating", 32'(quad2[7:0]), 32'hFF);
    press2(0);
    checkOutput("regen_timer_clr", 32'(quad2[31:16]), 32'd0);
    checkOutput("regen_banner", 32'(banner2), 32'd0);
    waitRun2("run_timeout_2");

    // Pause, then step the layout one frame at a time
    press2(1);
    checkOutput("paused_banner", 32'(banner2), 32'd1);
    checkOutput("paused_pause", 32'(gpause2), 32'h3);
    press2(2);
    repeat (3) @(negedge clk);
    checkOutput("mode_pending", 32'(quad2[11:8]), 32'h0);
    frameStart2();
    checkOutput("mode_solo0", 32'(quad2[11:8]), 32'h8);
    press2(2);
    frameStart2();
    checkOutput("mode_solo1", 32'(quad2[11:8]), 32'h9);

    // Solo focus 1: only game 1 runs, game 0 wins ignored
    press2(0);
    checkOutput("solo_running", 32'(running2), 32'h1);
    checkOutput("solo_pause", 32'(gpause2), 32'h1);
    win2 = 2'b01;
    @(negedge clk);
    win2 = '0;
    checkOutput("inactive_win", 32'(running2), 32'h1);
    h2 = 11'd100; v2 = 10'd10;
    #1;
    checkOutput("solo_tile_x", 32'(tile_x2), 32'd100);
    @(negedge clk);
    checkOutput("solo_pix", 32'(rgb2), 32'(G1_2));
    h2 = 11'd5; v2 = 10'd5;

    press2(1);
    press2(2);
    frameStart2();
    checkOutput("mode_split", 32'(quad2[11:8]), 32'h0);
    press2(0);
    press2(2);
    frameStart2();
    checkOutput("next_in_run", 32'(quad2[11:8]), 32'h0);

    // Divider region around the split boundary at 400
    h2 = 11'd398; v2 = 10'd10;
    @(negedge clk);
    h2 = 11'd399;
    checkOutput("pix_398", 32'(rgb2), 32'(EXP398));
    @(negedge clk);
    h2 = 11'd400;
    #1;
    checkOutput("tile_x_400", 32'(tile_x2), 32'd0);
    checkOutput("pix_399", 32'(rgb2), 32'(EXP399));
    @(negedge clk);
    checkOutput("pix_400", 32'(rgb2), 32'(G1_2));
    h2 = 11'd5; v2 = 10'd5;

    // Reset in the middle of REGEN cancels everything
    lose2 = 2'b10;
    @(negedge clk);
    lose2 = '0;
    press2(0);
    checkOutput("pre_rst_regen", 32'(regen2), 32'h3);
    arst_n = 1'b0;
    #1;
    checkOutput("mid_rst_regen", 32'(regen2), 32'h0);
    checkOutput("mid_rst_rgb", 32'(rgb2), 32'h0);
    checkOutput("mid_rst_pause", 32'(gpause2), 32'h3);
    checkOutput("mid_rst_rating", 32'(rating2), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("post_rst_regen%0d", i), 32'(regen2), 32'h0);
    end
    checkOutput("post_rst_idle", 32'(running2), 32'h0);

    // Four-game split layout table
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 8 && !running4; i++) @(negedge clk);
    checkOutput("dut4_running", 32'(running4), 32'h1);
    checkOutput("dut4_pause", 32'(gpause4), 32'h0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
